// File: rtl/spi_line_receiver.sv
// SPI slave line receiver: oversamples a mode-0 SPI link in the system clock domain, decodes
// one command byte per CS-framed transfer followed by one line of pixel bytes, and pushes
// accepted pixels into the downstream line FIFO.
module spi_line_receiver #(
  parameter int unsigned LINE_BYTES = 480,
  parameter logic [7:0]  CMD_FRAME  = 8'h3F,
  parameter logic [7:0]  CMD_LINE   = 8'h6B
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_clock,
  input  logic       spi_cs,
  input  logic       spi_data,
  input  logic       fifo_full,
  output logic [7:0] fifo_data,
  output logic       fifo_write,
  output logic       frame_start,
  output logic       line_start,
  output logic       line_done,
  output logic       line_error,
  output logic [1:0] error_code,
  output logic [7:0] line_index,
  output logic       overrun
);

  localparam logic [9:0] LineBytesW = 10'(LINE_BYTES);

  typedef enum logic [2:0] {StWaitIdle, StIdle, StCmd, StData, StDiscard} state_t;

  // Synchroniser and edge-detect stages
  logic [2:0] r_sck_sync;
  logic [2:0] r_cs_sync;
  logic [1:0] r_mosi_sync;
  logic       r_sck_rise;
  logic       r_cs_rise;
  logic       r_cs_fall;
  logic       r_mosi_bit;

  // Decoder state
  state_t     r_state,      w_state_next;
  logic [2:0] r_bit_cnt,    w_bit_cnt_next;
  logic [9:0] r_byte_cnt,   w_byte_cnt_next;
  logic [6:0] r_shift,      w_shift_next;
  logic [7:0] r_fifo_data,  w_fifo_data_next;
  logic       r_fifo_write, w_fifo_write_next;
  logic       r_frame_start, w_frame_start_next;
  logic       r_line_start, w_line_start_next;
  logic       r_line_done,  w_line_done_next;
  logic       r_line_error, w_line_error_next;
  logic [1:0] r_error_code, w_error_code_next;
  logic [7:0] r_line_index, w_line_index_next;
  logic       r_overrun,    w_overrun_next;
  logic [7:0] w_byte;

  // Two-flop synchronisers; the third SCK/CS flop and the registered edges form the detect stage
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sck_rise  <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_cs_fall   <= 1'b0;
      r_mosi_bit  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], spi_clock};
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs};
      r_mosi_sync <= {r_mosi_sync[0], spi_data};
      r_sck_rise  <= r_sck_sync[1] & ~r_sck_sync[2];
      r_cs_rise   <= r_cs_sync[1] & ~r_cs_sync[2];
      r_cs_fall   <= ~r_cs_sync[1] & r_cs_sync[2];
      // Data taken from the stage aligned with the SCK sample used for the edge
      r_mosi_bit  <= r_mosi_sync[1];
    end
  end

  assign w_byte = {r_shift, r_mosi_bit};

  // Next-state, counters and registered-output values
  always_comb begin
    w_state_next       = r_state;
    w_bit_cnt_next     = r_bit_cnt;
    w_byte_cnt_next    = r_byte_cnt;
    w_shift_next       = r_shift;
    w_fifo_data_next   = r_fifo_data;
    w_fifo_write_next  = 1'b0;
    w_frame_start_next = 1'b0;
    w_line_start_next  = 1'b0;
    w_line_done_next   = 1'b0;
    w_line_error_next  = 1'b0;
    w_error_code_next  = r_error_code;
    w_line_index_next  = r_line_index;
    w_overrun_next     = r_overrun;
    case (r_state)
      StWaitIdle: begin
        // A transfer already in flight when reset released is skipped entirely
        if (r_cs_sync[1]) w_state_next = StIdle;
      end
      StIdle: begin
        if (r_cs_fall) begin
          w_state_next    = StCmd;
          w_bit_cnt_next  = '0;
          w_byte_cnt_next = '0;
        end
      end
      StCmd, StData, StDiscard: begin
        if (r_cs_rise) begin
          // CS release wins over a coincident SCK edge
          w_state_next = StIdle;
          if (r_bit_cnt != 3'd0 || r_state == StCmd) begin
            w_line_error_next = 1'b1;
            w_error_code_next = 2'd3;
          end else if (r_state == StDiscard) begin
            w_line_error_next = 1'b1;
            w_error_code_next = 2'd2;
          end else if (r_byte_cnt < LineBytesW) begin
            w_line_error_next = 1'b1;
            w_error_code_next = 2'd0;
          end else if (r_byte_cnt > LineBytesW) begin
            w_line_error_next = 1'b1;
            w_error_code_next = 2'd1;
          end else begin
            w_line_done_next = 1'b1;
            if (r_line_index != 8'hFF) w_line_index_next = r_line_index + 8'd1;
          end
        end else if (r_sck_rise && r_state != StDiscard) begin
          w_shift_next   = w_byte[6:0];
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_state == StCmd) begin
              if (w_byte == CMD_FRAME) begin
                w_frame_start_next = 1'b1;
                w_line_start_next  = 1'b1;
                w_line_index_next  = '0;
                w_overrun_next     = 1'b0;
                w_state_next       = StData;
              end else if (w_byte == CMD_LINE) begin
                w_line_start_next = 1'b1;
                w_state_next      = StData;
              end else begin
                w_state_next = StDiscard;
              end
            end else begin
              // Saturate so a very long transfer can never wrap back to a legal count
              if (r_byte_cnt != 10'h3FF) w_byte_cnt_next = r_byte_cnt + 10'd1;
              if (r_byte_cnt < LineBytesW) begin
                if (!fifo_full) begin
                  w_fifo_write_next = 1'b1;
                  w_fifo_data_next  = w_byte;
                end else begin
                  w_overrun_next = 1'b1;
                end
              end
            end
          end
        end
      end
      default: w_state_next = StWaitIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= StWaitIdle;
      r_bit_cnt     <= '0;
      r_byte_cnt    <= '0;
      r_shift       <= '0;
      r_fifo_data   <= '0;
      r_fifo_write  <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_line_done   <= 1'b0;
      r_line_error  <= 1'b0;
      r_error_code  <= '0;
      r_line_index  <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_bit_cnt     <= w_bit_cnt_next;
      r_byte_cnt    <= w_byte_cnt_next;
      r_shift       <= w_shift_next;
      r_fifo_data   <= w_fifo_data_next;
      r_fifo_write  <= w_fifo_write_next;
      r_frame_start <= w_frame_start_next;
      r_line_start  <= w_line_start_next;
      r_line_done   <= w_line_done_next;
      r_line_error  <= w_line_error_next;
      r_error_code  <= w_error_code_next;
      r_line_index  <= w_line_index_next;
      r_overrun     <= w_overrun_next;
    end
  end

  assign fifo_data   = r_fifo_data;
  assign fifo_write  = r_fifo_write;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;
  assign line_done   = r_line_done;
  assign line_error  = r_line_error;
  assign error_code  = r_error_code;
  assign line_index  = r_line_index;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_spi_line_receiver.sv
// Directed bench for spi_line_receiver: expected pixel bytes are queued as they are shifted
// out on SPI and popped as the receiver writes them to the FIFO.
module tb_spi_line_receiver;

  localparam logic [7:0] CmdFrame = 8'h3F;
  localparam logic [7:0] CmdLine  = 8'h6B;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       spi_clock = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_data = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] fifo_data;
  logic       fifo_write;
  logic       frame_start;
  logic       line_start;
  logic       line_done;
  logic       line_error;
  logic [1:0] error_code;
  logic [7:0] line_index;
  logic       overrun;

  spi_line_receiver dut (
    .clock       (clock),
    .reset       (reset),
    .spi_clock   (spi_clock),
    .spi_cs      (spi_cs),
    .spi_data    (spi_data),
    .fifo_full   (fifo_full),
    .fifo_data   (fifo_data),
    .fifo_write  (fifo_write),
    .frame_start (frame_start),
    .line_start  (line_start),
    .line_done   (line_done),
    .line_error  (line_error),
    .error_code  (error_code),
    .line_index  (line_index),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  int         n_wr, n_fs, n_ls, n_done, n_err;
  int         cyc = 0;
  int         evt_cyc = 0;
  int         close_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard side: every FIFO write must match the oldest queued byte
  always @(negedge clock) begin
    if (fifo_write) begin
      n_wr++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL write_unexpected observed=%0h expected=none", fifo_data);
      end else begin
        exp_byte = exp_q.pop_front();
        assert (fifo_data === exp_byte) else begin
          bad++;
          $error("FAIL write_data observed=%0h expected=%0h", fifo_data, exp_byte);
        end
      end
    end
    if (frame_start) n_fs++;
    if (line_start) n_ls++;
    if (line_done) n_done++;
    if (line_error) n_err++;
    if (line_done || line_error) evt_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All drive tasks start and end 1 ns after a rising clock edge
  task automatic spi_bit(input logic b);
    spi_data = b;
    repeat (2) @(posedge clock);
    #1 spi_clock = 1'b1;
    repeat (2) @(posedge clock);
    #1 spi_clock = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] v, input logic full);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) fifo_full = full;
      spi_bit(v[i]);
    end
  endtask

  task automatic cs_open();
    n_wr = 0; n_fs = 0; n_ls = 0; n_done = 0; n_err = 0;
    spi_cs = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic cs_close();
    repeat (4) @(posedge clock);
    #1;
    close_cyc = cyc;
    spi_cs = 1'b1;
    repeat (12) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    repeat (3) @(posedge clock);
    #1;
    check("rst_fifo_write", fifo_write, 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_line_index", line_index, 0);
    check("rst_overrun", overrun, 0);
    check("rst_error_code", error_code, 0);
    check("rst_pulses", {frame_start, line_start, line_done, line_error}, 0);
    reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;

    // Frame line, bytes 0x00..0xDF wrapping
    cs_open();
    spi_byte(CmdFrame, 1'b0);
    for (int i = 0; i < 480; i++) begin
      v = 8'(i % 224);
      exp_q.push_back(v);
      spi_byte(v, 1'b0);
    end
    cs_close();
    check("a_queue_left", exp_q.size(), 0);
    check("a_writes", n_wr, 480);
    check("a_frame_start", n_fs, 1);
    check("a_line_start", n_ls, 1);
    check("a_line_done", n_done, 1);
    check("a_line_error", n_err, 0);
    check("a_line_index", line_index, 1);
    check("a_close_latency", evt_cyc - close_cyc, 4);

    // Next line with FIFO full across bytes 10..12
    cs_open();
    spi_byte(CmdLine, 1'b0);
    for (int i = 0; i < 480; i++) begin
      v = 8'($urandom_range(0, 255));
      if (i < 10 || i > 12) exp_q.push_back(v);
      spi_byte(v, (i >= 10 && i <= 12));
    end
    fifo_full = 1'b0;
    cs_close();
    check("b_queue_left", exp_q.size(), 0);
    check("b_writes", n_wr, 477);
    check("b_overrun", overrun, 1);
    check("b_frame_start", n_fs, 0);
    check("b_line_done", n_done, 1);
    check("b_line_error", n_err, 0);
    check("b_line_index", line_index, 2);

    // Short frame line: clears overrun and line_index, ends with code 0
    cs_open();
    spi_byte(CmdFrame, 1'b0);
    for (int i = 0; i < 30; i++) begin
      v = 8'($urandom_range(0, 255));
      exp_q.push_back(v);
      spi_byte(v, 1'b0);
    end
    cs_close();
    check("c_writes", n_wr, 30);
    check("c_frame_start", n_fs, 1);
    check("c_overrun_cleared", overrun, 0);
    check("c_line_error", n_err, 1);
    check("c_line_done", n_done, 0);
    check("c_error_code", error_code, 0);
    check("c_line_index", line_index, 0);

    // Long line of 482 bytes: only 480 written, code 1
    cs_open();
    spi_byte(CmdLine, 1'b0);
    for (int i = 0; i < 482; i++) begin
      v = 8'($urandom_range(0, 255));
      if (i < 480) exp_q.push_back(v);
      spi_byte(v, 1'b0);
    end
    cs_close();
    check("d_queue_left", exp_q.size(), 0);
    check("d_writes", n_wr, 480);
    check("d_line_error", n_err, 1);
    check("d_line_done", n_done, 0);
    check("d_error_code", error_code, 1);
    check("d_line_index", line_index, 0);
    check("d_close_latency", evt_cyc - close_cyc, 4);

    // Unknown command 0x55: payload discarded, code 2
    cs_open();
    spi_byte(8'h55, 1'b0);
    for (int i = 0; i < 10; i++) spi_byte(8'(i + 1), 1'b0);
    cs_close();
    check("e_writes", n_wr, 0);
    check("e_line_start", n_ls, 0);
    check("e_line_error", n_err, 1);
    check("e_error_code", error_code, 2);

    // CS released after 5 bits of a data byte: code 3
    cs_open();
    spi_byte(CmdLine, 1'b0);
    for (int i = 0; i < 2; i++) begin
      v = 8'($urandom_range(0, 255));
      exp_q.push_back(v);
      spi_byte(v, 1'b0);
    end
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    cs_close();
    check("f_line_start", n_ls, 1);
    check("f_writes", n_wr, 2);
    check("f_line_error", n_err, 1);
    check("f_error_code", error_code, 3);
    check("f_line_index", line_index, 0);

    // Reset mid-line with CS low: rest of the transfer must be ignored
    cs_open();
    spi_byte(CmdFrame, 1'b0);
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom_range(0, 255));
      exp_q.push_back(v);
      spi_byte(v, 1'b0);
    end
    repeat (8) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("g_rst_error_code", error_code, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) spi_byte(8'($urandom_range(0, 255)), 1'b0);
    cs_close();
    check("g_queue_left", exp_q.size(), 0);
    check("g_writes", n_wr, 5);
    check("g_line_done", n_done, 0);
    check("g_line_error", n_err, 0);

    // Full frame line after the aborted transfer
    cs_open();
    spi_byte(CmdFrame, 1'b0);
    for (int i = 0; i < 480; i++) begin
      v = 8'($urandom_range(0, 255));
      exp_q.push_back(v);
      spi_byte(v, 1'b0);
    end
    cs_close();
    check("h_queue_left", exp_q.size(), 0);
    check("h_writes", n_wr, 480);
    check("h_line_done", n_done, 1);
    check("h_line_error", n_err, 0);
    check("h_line_index", line_index, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
